// File: rtl/l1_cache_engine_if.sv
// l1_cache_engine_if
//   Bundles the trace-command handshake, the L2 request strobe, the response
//   strobe and the statistics outputs of one L1 engine.
//   master : trace source / consumer (drives cmd_*)
//   slave  : l1_cache_engine (drives everything else)
//   cmd_valid/cmd_ready/cmd_n/cmd_addr : command handshake
//   l2_valid/l2_wb/l2_addr             : L2 line request (wb=1 victim writeback)
//   resp_valid/resp_hit                : command completion
//   stats_valid, reads/writes/hits/misses : statistics
interface l1_cache_engine_if #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int CNT_W    = 32
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [3:0]                 cmd_n;
  logic [ADDR_W-1:0]          cmd_addr;
  logic                       l2_valid;
  logic                       l2_wb;
  logic [ADDR_W-OFFSET_W-1:0] l2_addr;
  logic                       resp_valid;
  logic                       resp_hit;
  logic                       stats_valid;
  logic [CNT_W-1:0]           reads;
  logic [CNT_W-1:0]           writes;
  logic [CNT_W-1:0]           hits;
  logic [CNT_W-1:0]           misses;

  modport master (
    output cmd_valid, cmd_n, cmd_addr,
    input  cmd_ready, l2_valid, l2_wb, l2_addr, resp_valid, resp_hit,
           stats_valid, reads, writes, hits, misses
  );

  modport slave (
    input  cmd_valid, cmd_n, cmd_addr,
    output cmd_ready, l2_valid, l2_wb, l2_addr, resp_valid, resp_hit,
           stats_valid, reads, writes, hits, misses
  );
endinterface

// File: rtl/l1_cache_engine.sv
// l1_cache_engine
//   Set-associative L1 tag/state engine with true-LRU replacement,
//   write-back/write-allocate, invalidate, flush and saturating statistics.
//   MODE=0 data cache (n=0 read, n=1 write), MODE=1 instruction cache
//   (n=0/n=2 fetch, never dirty).
//   clk   : clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : l1_cache_engine_if slave (command, L2 request, response, stats)
module l1_cache_engine #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 4,
  parameter int WAYS     = 4,
  parameter int CNT_W    = 32,
  parameter int MODE     = 0
) (
  input  logic             clk,
  input  logic             clear,
  l1_cache_engine_if.slave bus
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int TAG_W  = ADDR_W - OFFSET_W - INDEX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_RD, S_RESP, S_FLUSH} state_e;

  state_e              state_q;
  logic [LINE_W-1:0]   line_q;
  logic [3:0]          n_q;
  logic [INDEX_W-1:0]  flush_q;
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAY_W-1:0]    age_q   [SETS][WAYS];
  logic                l2_valid_q, l2_wb_q, resp_valid_q, resp_hit_q, stats_valid_q;
  logic [LINE_W-1:0]   l2_addr_q;
  logic [CNT_W-1:0]    reads_q, writes_q, hits_q, misses_q;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit, inv_found, vic_dirty;
  logic [WAY_W-1:0]    hit_way, vic_way, tgt_way;
  logic                is_rd, is_wr, is_inv;
  logic                unused_offset;

  // Byte offset never affects line state.
  assign unused_offset = ^bus.cmd_addr[OFFSET_W-1:0];

  assign idx    = line_q[INDEX_W-1:0];
  assign tag    = line_q[LINE_W-1 -: TAG_W];
  assign is_rd  = (n_q == 4'd0) || ((MODE != 0) && (n_q == 4'd2));
  assign is_wr  = (MODE == 0) && (n_q == 4'd1);
  assign is_inv = (n_q == 4'd3);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vic_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
    if (!inv_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
      end
    end
    tgt_way   = hit ? hit_way : vic_way;
    vic_dirty = valid_q[idx][vic_way] && dirty_q[idx][vic_way];
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Array updates (fill, dirty, LRU) all happen in LOOKUP; the victim tag for
  // a writeback is captured into l2_addr_q in the same edge, before the fill.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= S_IDLE;
      line_q        <= '0;
      n_q           <= '0;
      flush_q       <= '0;
      l2_valid_q    <= 1'b0;
      l2_wb_q       <= 1'b0;
      l2_addr_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      stats_valid_q <= 1'b0;
      reads_q       <= '0;
      writes_q      <= '0;
      hits_q        <= '0;
      misses_q      <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      l2_valid_q    <= 1'b0;
      l2_wb_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      stats_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            line_q <= bus.cmd_addr[ADDR_W-1:OFFSET_W];
            n_q    <= bus.cmd_n;
            if (bus.cmd_n == 4'd8) begin
              flush_q  <= '0;
              reads_q  <= '0;
              writes_q <= '0;
              hits_q   <= '0;
              misses_q <= '0;
              state_q  <= S_FLUSH;
            end else if (bus.cmd_n == 4'd9) begin
              stats_valid_q <= 1'b1;
            end else begin
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          if (is_rd || is_wr) begin
            if (is_rd) reads_q  <= sat_inc(reads_q);
            if (is_wr) writes_q <= sat_inc(writes_q);
            for (int unsigned w = 0; w < WAYS; w++) begin
              if (age_q[idx][w] < age_q[idx][tgt_way])
                age_q[idx][w] <= age_q[idx][w] + 1'b1;
            end
            age_q[idx][tgt_way] <= '0;
            if (hit) begin
              hits_q <= sat_inc(hits_q);
              if (is_wr) dirty_q[idx][hit_way] <= 1'b1;
              resp_valid_q <= 1'b1;
              resp_hit_q   <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              misses_q <= sat_inc(misses_q);
              tag_q[idx][vic_way]   <= tag;
              valid_q[idx][vic_way] <= 1'b1;
              dirty_q[idx][vic_way] <= is_wr;
              l2_valid_q <= 1'b1;
              if (vic_dirty) begin
                l2_wb_q   <= 1'b1;
                l2_addr_q <= {tag_q[idx][vic_way], idx};
                state_q   <= S_WB;
              end else begin
                l2_addr_q <= line_q;
                state_q   <= S_RD;
              end
            end
          end else begin
            if (is_inv && hit) begin
              valid_q[idx][hit_way] <= 1'b0;
              dirty_q[idx][hit_way] <= 1'b0;
            end
            resp_valid_q <= 1'b1;
            resp_hit_q   <= is_inv && hit;
            state_q      <= S_RESP;
          end
        end
        S_WB: begin
          l2_valid_q <= 1'b1;
          l2_addr_q  <= line_q;
          state_q    <= S_RD;
        end
        S_RD: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: state_q <= S_IDLE;
        S_FLUSH: begin
          valid_q[flush_q] <= '0;
          dirty_q[flush_q] <= '0;
          for (int unsigned w = 0; w < WAYS; w++) age_q[flush_q][w] <= WAY_W'(w);
          flush_q <= flush_q + 1'b1;
          if (flush_q == '1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.l2_valid    = l2_valid_q;
  assign bus.l2_wb       = l2_wb_q;
  assign bus.l2_addr     = l2_addr_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.stats_valid = stats_valid_q;
  assign bus.reads       = reads_q;
  assign bus.writes      = writes_q;
  assign bus.hits        = hits_q;
  assign bus.misses      = misses_q;
endmodule

// File: tb/tb_l1_cache_engine.sv
// tb_l1_cache_engine
//   Directed bench for two engines: a default data cache (sel=0) and an
//   instruction cache with 4-bit counters (sel=1). Each command is followed
//   by a fixed observation window; window slot i is the value seen at T+i.
module tb_l1_cache_engine;
  localparam int WIN = 24;

  logic        clk, clear, sel, cv;
  logic [3:0]  cn;
  logic [31:0] ca;

  l1_cache_engine_if #(.ADDR_W(32), .OFFSET_W(6), .CNT_W(32)) b0 ();
  l1_cache_engine_if #(.ADDR_W(32), .OFFSET_W(6), .CNT_W(4))  b1 ();

  l1_cache_engine #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(4), .WAYS(4), .CNT_W(32), .MODE(0))
    u_dcache (.clk(clk), .clear(clear), .bus(b0));
  l1_cache_engine #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(4), .WAYS(4), .CNT_W(4), .MODE(1))
    u_icache (.clk(clk), .clear(clear), .bus(b1));

  assign b0.cmd_valid = cv && !sel;
  assign b0.cmd_n     = cn;
  assign b0.cmd_addr  = ca;
  assign b1.cmd_valid = cv && sel;
  assign b1.cmd_n     = cn;
  assign b1.cmd_addr  = ca;

  logic        o_ready, o_l2v, o_wb, o_rv, o_rh, o_sv;
  logic [25:0] o_l2a;
  logic [31:0] o_reads, o_writes, o_hits, o_misses;
  assign o_ready  = sel ? b1.cmd_ready   : b0.cmd_ready;
  assign o_l2v    = sel ? b1.l2_valid    : b0.l2_valid;
  assign o_wb     = sel ? b1.l2_wb       : b0.l2_wb;
  assign o_l2a    = sel ? b1.l2_addr     : b0.l2_addr;
  assign o_rv     = sel ? b1.resp_valid  : b0.resp_valid;
  assign o_rh     = sel ? b1.resp_hit    : b0.resp_hit;
  assign o_sv     = sel ? b1.stats_valid : b0.stats_valid;
  assign o_reads  = sel ? 32'(b1.reads)  : b0.reads;
  assign o_writes = sel ? 32'(b1.writes) : b0.writes;
  assign o_hits   = sel ? 32'(b1.hits)   : b0.hits;
  assign o_misses = sel ? 32'(b1.misses) : b0.misses;

  int n_checks = 0;
  int n_errors = 0;

  int          resp_at, resp_cnt, l2_cnt, wb_cnt, stat_at, stat_cnt, busy;
  bit          resp_h;
  int          l2t [4];
  bit          l2w [4];
  logic [25:0] l2a [4];
  logic [31:0] stat_reads;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] n, input logic [31:0] a);
    int  w;
    bit  seen_ready;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) check("ready_wait", 32'(o_ready), 1);
    cv = 1'b1; cn = n; ca = a;
    @(posedge clk);
    #1 cv = 1'b0;
    resp_at = 0; resp_cnt = 0; resp_h = 1'b0; l2_cnt = 0; wb_cnt = 0;
    stat_at = 0; stat_cnt = 0; stat_reads = '0; busy = 0; seen_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      l2t[i] = 0; l2w[i] = 1'b0; l2a[i] = '0;
    end
    for (int i = 1; i <= WIN; i++) begin
      @(negedge clk);
      if (o_rv) begin
        if (resp_cnt == 0) begin
          resp_at = i;
          resp_h  = o_rh;
        end
        resp_cnt++;
      end
      if (o_l2v) begin
        if (l2_cnt < 4) begin
          l2t[l2_cnt] = i; l2w[l2_cnt] = o_wb; l2a[l2_cnt] = o_l2a;
        end
        l2_cnt++;
        if (o_wb) wb_cnt++;
      end
      if (o_sv) begin
        if (stat_cnt == 0) begin
          stat_at    = i;
          stat_reads = o_reads;
        end
        stat_cnt++;
      end
      if (o_ready) seen_ready = 1'b1;
      else if (!seen_ready) busy++;
    end
  endtask

  task automatic expect_miss(input string name, input logic [31:0] line);
    check({name, "_resp_at"}, resp_at, 3);
    check({name, "_hit"}, 32'(resp_h), 0);
    check({name, "_l2_cnt"}, l2_cnt, 1);
    check({name, "_l2_at"}, l2t[0], 2);
    check({name, "_l2_wb"}, 32'(l2w[0]), 0);
    check({name, "_l2_addr"}, 32'(l2a[0]), line);
  endtask

  task automatic expect_hit(input string name);
    check({name, "_resp_at"}, resp_at, 2);
    check({name, "_hit"}, 32'(resp_h), 1);
    check({name, "_l2_cnt"}, l2_cnt, 0);
  endtask

  initial begin
    sel = 1'b0; cv = 1'b0; cn = '0; ca = '0; clear = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready", 32'(o_ready), 1);
    check("rst_l2v", 32'(o_l2v), 0);
    check("rst_resp", 32'(o_rv), 0);
    check("rst_stats", 32'(o_sv), 0);
    check("rst_reads", o_reads, 0);
    check("rst_misses", o_misses, 0);

    // 1: miss then hit
    run_cmd(4'd0, 32'h1040); expect_miss("t1_rd1", 'h41);
    run_cmd(4'd0, 32'h1040); expect_hit("t1_rd2");
    check("t1_reads", o_reads, 2);
    check("t1_hits", o_hits, 1);
    check("t1_misses", o_misses, 1);

    // 2: fill set 0, LRU eviction
    run_cmd(4'd0, 32'h0000); expect_miss("t2_a", 'h00);
    run_cmd(4'd0, 32'h0400); expect_miss("t2_b", 'h10);
    run_cmd(4'd0, 32'h0800); expect_miss("t2_c", 'h20);
    run_cmd(4'd0, 32'h0C00); expect_miss("t2_d", 'h30);
    run_cmd(4'd0, 32'h1000); expect_miss("t2_e", 'h40);
    run_cmd(4'd0, 32'h0400); expect_hit("t2_rehit");
    run_cmd(4'd0, 32'h0000); expect_miss("t2_evicted", 'h00);

    // 3: dirty victim writeback
    run_cmd(4'd1, 32'h2000); expect_miss("t3_wr", 'h80);
    run_cmd(4'd0, 32'h2400); expect_miss("t3_a", 'h90);
    run_cmd(4'd0, 32'h2800); expect_miss("t3_b", 'hA0);
    run_cmd(4'd0, 32'h2C00); expect_miss("t3_c", 'hB0);
    run_cmd(4'd0, 32'h3000);
    check("t3_wb_cnt", l2_cnt, 2);
    check("t3_wb_at", l2t[0], 2);
    check("t3_wb_flag", 32'(l2w[0]), 1);
    check("t3_wb_addr", 32'(l2a[0]), 'h80);
    check("t3_rd_at", l2t[1], 3);
    check("t3_rd_flag", 32'(l2w[1]), 0);
    check("t3_rd_addr", 32'(l2a[1]), 'hC0);
    check("t3_resp_at", resp_at, 4);
    check("t3_resp_hit", 32'(resp_h), 0);

    // Unsupported n=2 on data cache, invalidate, re-miss
    run_cmd(4'd2, 32'h3000);
    check("unsup_resp_at", resp_at, 2);
    check("unsup_hit", 32'(resp_h), 0);
    check("unsup_l2", l2_cnt, 0);
    run_cmd(4'd3, 32'h3000);
    check("inv_resp_at", resp_at, 2);
    check("inv_hit", 32'(resp_h), 1);
    check("inv_l2", l2_cnt, 0);
    run_cmd(4'd0, 32'h3000); expect_miss("inv_remiss", 'hC0);
    check("pre_flush_reads", o_reads, 14);
    check("pre_flush_writes", o_writes, 1);
    check("pre_flush_hits", o_hits, 2);
    check("pre_flush_misses", o_misses, 13);

    // 4: flush and stats
    run_cmd(4'd8, 32'h0);
    check("t4_busy", busy, 16);
    check("t4_resp", resp_cnt, 0);
    check("t4_l2", l2_cnt, 0);
    check("t4_reads", o_reads, 0);
    check("t4_writes", o_writes, 0);
    check("t4_hits", o_hits, 0);
    check("t4_misses", o_misses, 0);
    run_cmd(4'd0, 32'h1040); expect_miss("t4_rd", 'h41);
    run_cmd(4'd9, 32'h0);
    check("t4_stat_at", stat_at, 1);
    check("t4_stat_cnt", stat_cnt, 1);
    check("t4_stat_reads", stat_reads, 1);
    check("t4_stat_resp", resp_cnt, 0);

    // 5: reset while in RD after a dirty writeback
    run_cmd(4'd1, 32'h0080); expect_miss("t5_wr", 'h02);
    run_cmd(4'd0, 32'h0480); expect_miss("t5_a", 'h12);
    run_cmd(4'd0, 32'h0880); expect_miss("t5_b", 'h22);
    run_cmd(4'd0, 32'h0C80); expect_miss("t5_c", 'h32);
    @(negedge clk);
    cv = 1'b1; cn = 4'd0; ca = 32'h1080;
    @(posedge clk);
    #1 cv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_wb_v", 32'(o_l2v), 1);
    check("t5_wb_flag", 32'(o_wb), 1);
    check("t5_wb_addr", 32'(o_l2a), 'h02);
    @(negedge clk);
    check("t5_rd_v", 32'(o_l2v), 1);
    #2 clear = 1'b0;
    #1;
    check("t5_rst_l2v", 32'(o_l2v), 0);
    check("t5_rst_wb", 32'(o_wb), 0);
    check("t5_rst_l2a", 32'(o_l2a), 0);
    check("t5_rst_resp", 32'(o_rv), 0);
    check("t5_rst_rhit", 32'(o_rh), 0);
    check("t5_rst_stats", 32'(o_sv), 0);
    check("t5_rst_reads", o_reads, 0);
    check("t5_rst_ready", 32'(o_ready), 1);
    @(negedge clk);
    clear = 1'b1;
    run_cmd(4'd0, 32'h1080); expect_miss("t5_post", 'h42);
    check("t5_post_wb", wb_cnt, 0);

    // 6: instruction cache, 4-bit saturating counters
    sel = 1'b1;
    run_cmd(4'd1, 32'h40);
    check("t6_wr_resp_at", resp_at, 2);
    check("t6_wr_hit", 32'(resp_h), 0);
    check("t6_wr_l2", l2_cnt, 0);
    check("t6_wr_reads", o_reads, 0);
    check("t6_wr_writes", o_writes, 0);
    check("t6_wr_misses", o_misses, 0);
    run_cmd(4'd2, 32'h40); expect_miss("t6_first", 'h01);
    for (int i = 0; i < 16; i++) run_cmd(4'd2, 32'h40);
    expect_hit("t6_last");
    check("t6_reads", o_reads, 15);
    check("t6_writes", o_writes, 0);
    check("t6_hits", o_hits, 15);
    check("t6_misses", o_misses, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
